// File: rtl/dm_pkg.sv
// Shared encodings and lane helpers for the multi-cycle data-memory stage.
package dm_pkg;

    typedef enum logic [2:0] {
        OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB
    } dm_op_e;

    typedef enum logic [1:0] {
        ST_CLEAR, ST_IDLE, ST_WAIT, ST_RESP
    } dm_state_e;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    function automatic logic is_store(dm_op_e op);
        return op inside {OP_SW, OP_SH, OP_SB};
    endfunction

    function automatic logic is_aligned(dm_op_e op, logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:         return lo == 2'd0;
            OP_LH, OP_LHU, OP_SH: return !lo[0];
            default:              return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] be_gen(dm_op_e op, logic [1:0] lo);
        case (op)
            OP_SW:   return 4'b1111;
            OP_SH:   return 4'b0011 << lo;
            OP_SB:   return 4'b0001 << lo;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate store data to every lane; the byte enables pick the live ones.
    function automatic logic [31:0] st_rep(dm_op_e op, logic [31:0] wdata);
        case (op)
            OP_SH:   return {2{wdata[15:0]}};
            OP_SB:   return {4{wdata[7:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] ld_ext(dm_op_e op, logic [31:0] word, logic [1:0] lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LW:   return word;
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0000, h};
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h000000, b};
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/dm_stage_mc_array.sv
// Word memory with synchronous byte-enabled write and asynchronous read; no reset.
module dm_array #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dm_stage_mc.sv
// MEM-stage load/store unit: post-reset clear, alignment/range traps,
// LAT wait states and load extension, stalling the pipeline while busy.
module dm_stage_mc
    import dm_pkg::*;
#(
    parameter int          ADDR_W = 12,
    parameter int          LAT    = 2,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  dm_op_e      op,
    input  logic        flush,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        stall,
    output logic        ready,
    output logic        exc,
    output logic [4:0]  exc_code,
    output dm_state_e   state_dbg
);

    localparam bit          SINGLE = (LAT == 0);
    localparam logic [3:0]  LAT_M1 = SINGLE ? 4'd0 : 4'(LAT - 1);
    localparam logic [32:0] SPAN   = 33'(2**ADDR_W) << 2;

    dm_state_e         state, state_nx;
    logic [ADDR_W-1:0] clr_ptr;
    logic [3:0]        cnt;
    dm_op_e            op_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [1:0]        lo_q;
    logic [31:0]       rdata_q;

    logic [31:0]       off;
    logic              legal, acc, bad;
    logic [ADDR_W-1:0] word_a;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata, mem_rdata;

    // Offset into the window; the 33-bit compare keeps the top of a 4 GiB span exact.
    assign off    = addr - BASE;
    assign legal  = (addr >= BASE) && ({1'b0, off} < SPAN) && is_aligned(op, addr[1:0]);
    assign acc    = (state == ST_IDLE) && req_valid && legal;
    assign bad    = (state == ST_IDLE) && req_valid && !legal;
    assign word_a = off[ADDR_W+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            cnt     <= 4'd0;
            op_q    <= OP_LW;
            waddr_q <= '0;
            be_q    <= 4'd0;
            wdata_q <= 32'h0;
            lo_q    <= 2'd0;
            rdata_q <= 32'h0;
        end else begin
            state <= state_nx;
            case (state)
                ST_CLEAR: clr_ptr <= clr_ptr + ADDR_W'(1);
                ST_IDLE: begin
                    if (acc && !SINGLE) begin
                        op_q    <= op;
                        waddr_q <= word_a;
                        be_q    <= be_gen(op, addr[1:0]);
                        wdata_q <= st_rep(op, wdata);
                        lo_q    <= addr[1:0];
                        cnt     <= LAT_M1;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0)                        cnt     <= cnt - 4'd1;
                    else if (!flush && !is_store(op_q))     rdata_q <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_CLEAR: if (clr_ptr == '1) state_nx = ST_IDLE;
            ST_IDLE:  if (acc && !SINGLE) state_nx = ST_WAIT;
            ST_WAIT: begin
                if (flush)              state_nx = ST_IDLE;
                else if (cnt == 4'd0)   state_nx = ST_RESP;
            end
            ST_RESP:  state_nx = ST_IDLE;
            default:  state_nx = ST_CLEAR;
        endcase
    end

    always_comb begin
        stall     = 1'b0;
        done      = 1'b0;
        exc       = 1'b0;
        exc_code  = EXC_NONE;
        rdata     = 32'h0;
        ready     = (state != ST_CLEAR);
        mem_we    = 1'b0;
        mem_waddr = word_a;
        mem_be    = 4'd0;
        mem_wdata = 32'h0;
        mem_raddr = (state == ST_WAIT) ? waddr_q : word_a;
        case (state)
            ST_CLEAR: begin
                stall     = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = clr_ptr;
                mem_be    = 4'b1111;
            end
            ST_IDLE: begin
                if (bad) begin
                    exc      = 1'b1;
                    exc_code = is_store(op) ? EXC_ADES : EXC_ADEL;
                end else if (acc && SINGLE) begin
                    done = 1'b1;
                    if (is_store(op)) begin
                        mem_we    = 1'b1;
                        mem_be    = be_gen(op, addr[1:0]);
                        mem_wdata = st_rep(op, wdata);
                    end else begin
                        rdata = ld_ext(op, mem_rdata, addr[1:0]);
                    end
                end else if (acc) begin
                    stall = 1'b1;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                // Flush wins even on the final wait cycle, so the store never lands.
                if (cnt == 4'd0 && !flush && is_store(op_q)) begin
                    mem_we    = 1'b1;
                    mem_waddr = waddr_q;
                    mem_be    = be_q;
                    mem_wdata = wdata_q;
                end
            end
            ST_RESP: begin
                done = 1'b1;
                if (!is_store(op_q)) rdata = ld_ext(op_q, rdata_q, lo_q);
            end
            default: ;
        endcase
    end

    assign state_dbg = state;

    dm_array #(.ADDR_W(ADDR_W)) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .be    (mem_be),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dm_stage_mc.sv
// Directed bench for dm_stage_mc: a LAT=2 instance and a LAT=0 instance, both 16 words deep.
module tb_dm_stage_mc;
    import dm_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        a_req_valid = 1'b0, a_flush = 1'b0;
    dm_op_e      a_op = OP_LW;
    logic [31:0] a_addr = 32'h0, a_wdata = 32'h0, a_rdata;
    logic        a_done, a_stall, a_ready, a_exc;
    logic [4:0]  a_exc_code;
    dm_state_e   a_state;

    logic        b_req_valid = 1'b0, b_flush = 1'b0;
    dm_op_e      b_op = OP_LW;
    logic [31:0] b_addr = 32'h0, b_wdata = 32'h0, b_rdata;
    logic        b_done, b_stall, b_ready, b_exc;
    logic [4:0]  b_exc_code;
    dm_state_e   b_state;

    dm_stage_mc #(.ADDR_W(4), .LAT(2), .BASE(32'h0)) u_a (
        .clk(clk), .reset(reset), .req_valid(a_req_valid), .op(a_op), .flush(a_flush),
        .addr(a_addr), .wdata(a_wdata), .rdata(a_rdata), .done(a_done), .stall(a_stall),
        .ready(a_ready), .exc(a_exc), .exc_code(a_exc_code), .state_dbg(a_state)
    );

    dm_stage_mc #(.ADDR_W(4), .LAT(0), .BASE(32'h0)) u_b (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .op(b_op), .flush(b_flush),
        .addr(b_addr), .wdata(b_wdata), .rdata(b_rdata), .done(b_done), .stall(b_stall),
        .ready(b_ready), .exc(b_exc), .exc_code(b_exc_code), .state_dbg(b_state)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        dm_op_e      op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          flush_cyc;
        bit          exp_done;
        bit          exp_exc;
        logic [4:0]  exp_code;
        int          exp_stalls;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input dm_op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                           input int flush_cyc, input bit exp_done, input bit exp_exc,
                           input logic [4:0] exp_code, input int exp_stalls,
                           input logic [31:0] exp_rdata);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.flush_cyc = flush_cyc;
        v.exp_done = exp_done; v.exp_exc = exp_exc; v.exp_code = exp_code;
        v.exp_stalls = exp_stalls; v.exp_rdata = exp_rdata;
        vecs.push_back(v);
    endtask

    // One access on the LAT=2 instance; ends on done, exc or the flushed cycle.
    task automatic access_a(input dm_op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                            input int flush_cyc, output logic [31:0] rd, output int stalls,
                            output bit got_done, output bit got_exc, output logic [4:0] code);
        bit fin;
        fin = 1'b0;
        rd = 32'h0; stalls = 0; got_done = 1'b0; got_exc = 1'b0; code = 5'd0;
        a_req_valid = 1'b1; a_op = op; a_addr = addr; a_wdata = wdata;
        for (int i = 0; i < 20 && !fin; i++) begin
            a_flush = (i == flush_cyc);
            @(negedge clk);
            if (a_stall) stalls++;
            if (a_exc) begin got_exc = 1'b1; code = a_exc_code; rd = a_rdata; end
            if (a_done) begin got_done = 1'b1; rd = a_rdata; end
            fin = a_exc || a_done || a_flush;
            @(posedge clk); #1;
        end
        a_req_valid = 1'b0; a_flush = 1'b0;
        if (!fin) begin
            checks++; errors++;
            $display("FAIL access_timeout op=%s addr=%h", op.name(), addr);
        end
    endtask

    // Releases reset and counts the clear-phase stall cycles on both instances.
    task automatic do_clear();
        int  na, nb;
        bit  a_low, b_low;
        na = 0; nb = 0; a_low = 1'b0; b_low = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 100 && !(a_low && b_low); i++) begin
            @(negedge clk);
            if (a_stall && !a_low) na++; else a_low = 1'b1;
            if (b_stall && !b_low) nb++; else b_low = 1'b1;
            @(posedge clk); #1;
        end
        chk("clear_stall_cycles_lat2", 32'(na), 32'd16);
        chk("clear_stall_cycles_lat0", 32'(nb), 32'd16);
        chk("ready_after_clear_lat2", 32'(a_ready), 32'd1);
        chk("ready_after_clear_lat0", 32'(b_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          st;
        bit          dn, ex;
        logic [4:0]  cd;

        // Reset values while held in reset.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_stall", 32'(a_stall), 32'd1);
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_exc", 32'(a_exc), 32'd0);
        chk("rst_exc_code", 32'(a_exc_code), 32'd0);
        chk("rst_rdata", a_rdata, 32'h0);
        chk("rst_state", 32'(a_state), 32'(ST_CLEAR));
        chk("rst_stall_lat0", 32'(b_stall), 32'd1);
        @(posedge clk); #1;
        do_clear();

        // Every word reads back zero after the clear.
        for (int w = 0; w < 16; w++) begin
            access_a(OP_LW, 32'(w * 4), 32'h0, -1, rd, st, dn, ex, cd);
            chk("clear_lw_done", 32'(dn), 32'd1);
            chk("clear_lw_rdata", rd, 32'h0);
        end

        // SW timing: memory word stays old until the final wait edge.
        a_req_valid = 1'b1; a_op = OP_SW; a_addr = 32'h8; a_wdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sw_stall", 32'(a_stall), (i < 3) ? 32'd1 : 32'd0);
            chk("sw_done", 32'(a_done), (i == 3) ? 32'd1 : 32'd0);
            chk("sw_mem_word2", u_a.u_array.mem[2], (i == 3) ? 32'h1234_5678 : 32'h0);
            @(posedge clk); #1;
        end
        a_req_valid = 1'b0;

        //        op      addr     wdata          flush done exc code      stalls rdata
        add_vec(OP_LB,  32'hB,  32'h0,           -1, 1, 0, EXC_NONE, 3, 32'h0000_0012);
        add_vec(OP_LBU, 32'h9,  32'h0,           -1, 1, 0, EXC_NONE, 3, 32'h0000_0056);
        add_vec(OP_LH,  32'hA,  32'h0,           -1, 1, 0, EXC_NONE, 3, 32'h0000_1234);
        add_vec(OP_LW,  32'h8,  32'h0,           -1, 1, 0, EXC_NONE, 3, 32'h1234_5678);
        add_vec(OP_LH,  32'h8,  32'h0,           -1, 1, 0, EXC_NONE, 3, 32'h0000_5678);
        add_vec(OP_SB,  32'h1,  32'h0000_0080,   -1, 1, 0, EXC_NONE, 3, 32'h0);
        add_vec(OP_LB,  32'h1,  32'h0,           -1, 1, 0, EXC_NONE, 3, 32'hFFFF_FF80);
        add_vec(OP_LBU, 32'h1,  32'h0,           -1, 1, 0, EXC_NONE, 3, 32'h0000_0080);
        add_vec(OP_LW,  32'h0,  32'h0,           -1, 1, 0, EXC_NONE, 3, 32'h0000_8000);
        add_vec(OP_LW,  32'h2,  32'h0,           -1, 0, 1, EXC_ADEL, 0, 32'h0);
        add_vec(OP_SH,  32'h3,  32'h0000_AAAA,   -1, 0, 1, EXC_ADES, 0, 32'h0);
        add_vec(OP_LW,  32'h0,  32'h0,           -1, 1, 0, EXC_NONE, 3, 32'h0000_8000);
        add_vec(OP_SW,  32'h40, 32'h0000_0001,   -1, 0, 1, EXC_ADES, 0, 32'h0);
        add_vec(OP_LW,  32'h40, 32'h0,           -1, 0, 1, EXC_ADEL, 0, 32'h0);
        add_vec(OP_SW,  32'h4,  32'hDEAD_BEEF,    2, 0, 0, EXC_NONE, 3, 32'h0);
        add_vec(OP_LW,  32'h4,  32'h0,           -1, 1, 0, EXC_NONE, 3, 32'h0);
        add_vec(OP_SH,  32'h6,  32'h0000_C3A5,   -1, 1, 0, EXC_NONE, 3, 32'h0);
        add_vec(OP_LH,  32'h6,  32'h0,           -1, 1, 0, EXC_NONE, 3, 32'hFFFF_C3A5);
        add_vec(OP_LHU, 32'h6,  32'h0,           -1, 1, 0, EXC_NONE, 3, 32'h0000_C3A5);
        add_vec(OP_LW,  32'h4,  32'h0,           -1, 1, 0, EXC_NONE, 3, 32'hC3A5_0000);
        add_vec(OP_SB,  32'h3F, 32'h0000_007F,   -1, 1, 0, EXC_NONE, 3, 32'h0);
        add_vec(OP_LW,  32'h3C, 32'h0,           -1, 1, 0, EXC_NONE, 3, 32'h7F00_0000);
        add_vec(OP_LB,  32'h3F, 32'h0,           -1, 1, 0, EXC_NONE, 3, 32'h0000_007F);
        add_vec(OP_LH,  32'h3E, 32'h0,           -1, 1, 0, EXC_NONE, 3, 32'h0000_7F00);

        foreach (vecs[k]) begin
            access_a(vecs[k].op, vecs[k].addr, vecs[k].wdata, vecs[k].flush_cyc, rd, st, dn, ex, cd);
            chk($sformatf("v%0d_done", k), 32'(dn), 32'(vecs[k].exp_done));
            chk($sformatf("v%0d_exc", k), 32'(ex), 32'(vecs[k].exp_exc));
            chk($sformatf("v%0d_code", k), 32'(cd), 32'(vecs[k].exp_code));
            chk($sformatf("v%0d_stalls", k), 32'(st), 32'(vecs[k].exp_stalls));
            chk($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rdata);
        end

        // LAT=0: back-to-back SW then loads, never stalling.
        b_req_valid = 1'b1; b_op = OP_SW; b_addr = 32'h14; b_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("l0_sw_stall", 32'(b_stall), 32'd0);
        chk("l0_sw_done", 32'(b_done), 32'd1);
        @(posedge clk); #1;
        b_op = OP_LW;
        @(negedge clk);
        chk("l0_lw_stall", 32'(b_stall), 32'd0);
        chk("l0_lw_done", 32'(b_done), 32'd1);
        chk("l0_lw_rdata", b_rdata, 32'hCAFE_F00D);
        @(posedge clk); #1;
        b_op = OP_LB; b_addr = 32'h17;
        @(negedge clk);
        chk("l0_lb_rdata", b_rdata, 32'hFFFF_FFCA);
        @(posedge clk); #1;
        b_op = OP_LHU; b_addr = 32'h14;
        @(negedge clk);
        chk("l0_lhu_rdata", b_rdata, 32'h0000_F00D);
        @(posedge clk); #1;
        b_op = OP_LH; b_addr = 32'h15;
        @(negedge clk);
        chk("l0_lh_exc", 32'(b_exc), 32'd1);
        chk("l0_lh_code", 32'(b_exc_code), 32'(EXC_ADEL));
        chk("l0_lh_done", 32'(b_done), 32'd0);
        chk("l0_lh_stall", 32'(b_stall), 32'd0);
        @(posedge clk); #1;
        b_op = OP_SW; b_addr = 32'h40;
        @(negedge clk);
        chk("l0_sw_range_code", 32'(b_exc_code), 32'(EXC_ADES));
        @(posedge clk); #1;
        b_req_valid = 1'b0;

        // Reset in the middle of a LAT=2 store: back to CLEAR, store lost.
        a_req_valid = 1'b1; a_op = OP_SW; a_addr = 32'hC; a_wdata = 32'h1111_1111;
        @(negedge clk);
        chk("mid_accept_stall", 32'(a_stall), 32'd1);
        @(posedge clk); #1;
        chk("mid_in_wait", 32'(a_state), 32'(ST_WAIT));
        reset = 1'b0;
        #1;
        chk("mid_rst_state", 32'(a_state), 32'(ST_CLEAR));
        chk("mid_rst_stall", 32'(a_stall), 32'd1);
        chk("mid_rst_ready", 32'(a_ready), 32'd0);
        a_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_clear();
        access_a(OP_LW, 32'hC, 32'h0, -1, rd, st, dn, ex, cd);
        chk("post_rst_lw_c", rd, 32'h0);
        access_a(OP_LW, 32'h8, 32'h0, -1, rd, st, dn, ex, cd);
        chk("post_rst_lw_8", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
